// File: rtl/ifid_fetch_stage.sv
// Fetch stage with PC register, IF/ID pipeline register and the registered flag/rd pair fed back to the hazard unit.
// Optional macro FETCH_PERF_EN adds stall_cnt/flush_cnt performance counters.
module ifid_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        pc_en,
    input  logic        flush_n,
    input  logic        bubble_n,
    input  logic [1:0]  tag,
    output logic [31:0] ifid_ins,
    output logic [31:0] ifid_pc4,
    output logic [1:0]  flag,
    output logic [4:0]  rd
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    logic [31:0] r_pc;
    logic [31:0] r_ifid_ins;
    logic [31:0] r_ifid_pc4;
    logic [1:0]  r_flag;
    logic [4:0]  r_rd;

    logic [31:0] w_pc4;
    logic [31:0] w_bt;
    logic [31:0] w_jt;
    logic [31:0] w_pc_next;

    assign w_pc4 = r_pc + 32'd4;
    assign w_bt  = r_ifid_pc4 + {{14{r_ifid_ins[15]}}, r_ifid_ins[15:0], 2'b00};
    assign w_jt  = {r_ifid_pc4[31:28], r_ifid_ins[25:0], 2'b00};

    // tag is only decoded when advancing, so a garbage tag during a stall cannot move the PC
    always_comb begin
        w_pc_next = r_pc;
        if (pc_en) begin
            case (tag)
                2'd2:    w_pc_next = w_bt;
                2'd3:    w_pc_next = w_jt;
                default: w_pc_next = w_pc4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_ifid_ins <= NOP_WORD;
            r_ifid_pc4 <= 32'd0;
        end else begin
            r_pc <= w_pc_next;
            if (pc_en) begin
                if (!flush_n) begin
                    r_ifid_ins <= NOP_WORD;
                    r_ifid_pc4 <= 32'd0;
                end else begin
                    r_ifid_ins <= imem_rdata;
                    r_ifid_pc4 <= w_pc4;
                end
            end
        end
    end

    // flag/rd track the instruction entering EX, so they advance even while fetch is stalled
    always_ff @(posedge clk) begin
        if (!rst_n || !bubble_n) begin
            r_flag <= 2'd0;
            r_rd   <= 5'd0;
        end else begin
            r_flag <= tag;
            r_rd   <= r_ifid_ins[20:16];
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (!pc_en)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (pc_en && !flush_n)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

    assign imem_addr = r_pc;
    assign ifid_ins  = r_ifid_ins;
    assign ifid_pc4  = r_ifid_pc4;
    assign flag      = r_flag;
    assign rd        = r_rd;

endmodule

// File: tb/tb_ifid_fetch_stage.sv
// Directed bench for ifid_fetch_stage: reset, load-use stall, beq/j redirects, stall-over-redirect, PC wrap, mid-stall reset.
// A second instance with a high RESET_PC reaches the upper-nibble region needed for the jump vector.
module tb_ifid_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_rdata;
    logic        pc_en;
    logic        flush_n;
    logic        bubble_n;
    logic [1:0]  tag;

    logic [31:0] imem_addr, ifid_ins, ifid_pc4;
    logic [1:0]  flag;
    logic [4:0]  rd;
    logic [31:0] hi_imem_addr, hi_ifid_ins, hi_ifid_pc4;
    logic [1:0]  hi_flag;
    logic [4:0]  hi_rd;

    int checks = 0;
    int errors = 0;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, hi_stall_cnt, hi_flush_cnt;
`endif

    ifid_fetch_stage u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .pc_en      (pc_en),
        .flush_n    (flush_n),
        .bubble_n   (bubble_n),
        .tag        (tag),
        .ifid_ins   (ifid_ins),
        .ifid_pc4   (ifid_pc4),
        .flag       (flag),
        .rd         (rd)
`ifdef FETCH_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    ifid_fetch_stage #(.RESET_PC(32'h4000_0018)) u_dut_hi (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (hi_imem_addr),
        .imem_rdata (imem_rdata),
        .pc_en      (pc_en),
        .flush_n    (flush_n),
        .bubble_n   (bubble_n),
        .tag        (tag),
        .ifid_ins   (hi_ifid_ins),
        .ifid_pc4   (hi_ifid_pc4),
        .flag       (hi_flag),
        .rd         (hi_rd)
`ifdef FETCH_PERF_EN
        ,
        .stall_cnt  (hi_stall_cnt),
        .flush_cnt  (hi_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, obs, exp);
        end
    endtask

    task automatic expect_main(input string name, input logic [31:0] e_pc, input logic [31:0] e_ins,
                               input logic [31:0] e_pc4, input logic [1:0] e_flag, input logic [4:0] e_rd);
        chk({name, ".pc"},   imem_addr, e_pc);
        chk({name, ".ins"},  ifid_ins,  e_ins);
        chk({name, ".pc4"},  ifid_pc4,  e_pc4);
        chk({name, ".flag"}, {30'd0, flag}, {30'd0, e_flag});
        chk({name, ".rd"},   {27'd0, rd},   {27'd0, e_rd});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t rst_n=%0b pc_en=%0b flush_n=%0b bubble_n=%0b tag=%0d | pc=%h ins=%h pc4=%h flag=%0d rd=%0d",
                 $time, rst_n, pc_en, flush_n, bubble_n, tag, imem_addr, ifid_ins, ifid_pc4, flag, rd);
    endtask

    task automatic norm();
        pc_en    = 1'b1;
        flush_n  = 1'b1;
        bubble_n = 1'b1;
        tag      = 2'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        norm();
        imem_rdata = 32'd0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        norm();
        imem_rdata = 32'd0;

        // 1: reset and first fetches
        step();
        step();
        expect_main("reset", 32'h0, 32'h0, 32'h0, 2'd0, 5'd0);
        rst_n = 1'b1;
        imem_rdata = 32'h2008_0005;
        step();
        expect_main("fetch1", 32'h4, 32'h2008_0005, 32'h4, 2'd0, 5'd0);
        step();
        expect_main("fetch2", 32'h8, 32'h2008_0005, 32'h8, 2'd0, 5'd8);

        // 2: load-use stall
        imem_rdata = 32'h8C08_0000;
        step();
        expect_main("lw_fetch", 32'hC, 32'h8C08_0000, 32'hC, 2'd0, 5'd8);
        tag = 2'd1;
        imem_rdata = 32'h0109_4820;
        step();
        expect_main("lw_to_ex", 32'h10, 32'h0109_4820, 32'h10, 2'd1, 5'd8);
        pc_en = 1'b0;
        bubble_n = 1'b0;
        tag = 2'd0;
        step();
        expect_main("lu_stall", 32'h10, 32'h0109_4820, 32'h10, 2'd0, 5'd0);
        norm();
        imem_rdata = 32'd0;
        step();
        expect_main("lu_resume", 32'h14, 32'h0, 32'h14, 2'd0, 5'd9);

        // 3: taken beq with negative offset
        do_reset();
        for (int i = 0; i < 3; i++) step();
        imem_rdata = 32'h1000_FFFE;
        step();
        expect_main("beq_in_id", 32'h10, 32'h1000_FFFE, 32'h10, 2'd0, 5'd0);
        tag = 2'd2;
        flush_n = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        expect_main("beq_taken", 32'h8, 32'h0, 32'h0, 2'd2, 5'd0);
        norm();
        bubble_n = 1'b0;
        imem_rdata = 32'd0;
        step();
        expect_main("beq_bubble", 32'hC, 32'h0, 32'hC, 2'd0, 5'd0);

        // 4: jump, main instance in low region and hi instance at 0x4000_0020
        do_reset();
        chk("hi_reset.pc", hi_imem_addr, 32'h4000_0018);
        step();
        imem_rdata = 32'h0800_0040;
        step();
        chk("hi_j_in_id.pc",  hi_imem_addr, 32'h4000_0020);
        chk("hi_j_in_id.pc4", hi_ifid_pc4,  32'h4000_0020);
        chk("hi_j_in_id.ins", hi_ifid_ins,  32'h0800_0040);
        tag = 2'd3;
        flush_n = 1'b0;
        step();
        chk("hi_jump.pc",   hi_imem_addr, 32'h4000_0100);
        chk("hi_jump.pc4",  hi_ifid_pc4,  32'h0);
        chk("hi_jump.ins",  hi_ifid_ins,  32'h0);
        chk("hi_jump.flag", {30'd0, hi_flag}, 32'd3);
        expect_main("lo_jump", 32'h100, 32'h0, 32'h0, 2'd3, 5'd0);

        // 5: stall wins over redirect, then redirect on release
        do_reset();
        imem_rdata = 32'h1000_0003;
        step();
        expect_main("sr_in_id", 32'h4, 32'h1000_0003, 32'h4, 2'd0, 5'd0);
        tag = 2'd2;
        pc_en = 1'b0;
        flush_n = 1'b0;
        bubble_n = 1'b0;
        step();
        expect_main("sr_stall", 32'h4, 32'h1000_0003, 32'h4, 2'd0, 5'd0);
        pc_en = 1'b1;
        bubble_n = 1'b1;
        step();
        expect_main("sr_release", 32'h10, 32'h0, 32'h0, 2'd2, 5'd0);

        // 6: wrap through 0xFFFF_FFFC, then reset during a stall
        do_reset();
        imem_rdata = 32'h1000_FFFE;
        step();
        expect_main("wr_in_id", 32'h4, 32'h1000_FFFE, 32'h4, 2'd0, 5'd0);
        tag = 2'd2;
        flush_n = 1'b0;
        step();
        expect_main("wr_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 2'd2, 5'd0);
        norm();
        bubble_n = 1'b0;
        imem_rdata = 32'h2008_0005;
        step();
        expect_main("wr_wrap", 32'h0, 32'h2008_0005, 32'h0, 2'd0, 5'd0);
        norm();
        step();
        expect_main("wr_next", 32'h4, 32'h2008_0005, 32'h4, 2'd0, 5'd8);
        pc_en = 1'b0;
        tag = 2'd2;
        rst_n = 1'b0;
        step();
        expect_main("stall_rst", 32'h0, 32'h0, 32'h0, 2'd0, 5'd0);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifid_fetch_stage.md
Name: ifid_fetch_stage

Overview:
Fetch stage plus IF/ID pipeline register of the 5-stage MIPS core. It owns the PC and drives the instruction-memory address. It latches the fetched word into IF/ID and selects the next PC from PC+4, the beq target or the j target. It also registers the hazard unit's tag and destination register into the flag/rd pair, which feeds the hazard unit back on the following cycle.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush and reset.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
imem_addr  output  32  instruction-memory address; equals PC register.
imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle (combinational ROM).
pc_en  input  1  1 = advance PC and IF/ID; 0 = stall (hold both).
flush_n  input  1  active-low squash: 0 = load NOP_WORD into IF/ID.
bubble_n  input  1  active-low bubble: 0 = clear flag/rd (NOP into ID/EX).
tag  input  2  class of instruction in ID: 0 other, 1 lw, 2 beq taken, 3 j.
ifid_ins  output  32  instruction held in IF/ID (to decode and hazard unit).
ifid_pc4  output  32  PC+4 of the instruction in IF/ID.
flag  output  2  registered tag of instruction now in EX.
rd  output  5  registered ifid_ins[20:16] of instruction now in EX.

Behaviour:
- Reset: when rst_n=0 at a posedge, load pc=RESET_PC, ifid_ins=NOP_WORD, ifid_pc4=0, flag=0, rd=0. Reset overrides every other input, including mid-stall and mid-redirect.
- Branch target: bt = ifid_pc4 + ({{14{ifid_ins[15]}}, ifid_ins[15:0], 2'b00}), modulo 2^32.
- Jump target: jt = {ifid_pc4[31:28], ifid_ins[25:0], 2'b00}.
- PC update per cycle:
  - pc_en=0: pc holds. Stall has priority over redirect.
  - pc_en=1, tag=2: pc <= bt.
  - pc_en=1, tag=3: pc <= jt.
  - pc_en=1, tag=0 or 1: pc <= pc+4. Wraps from 32'hFFFF_FFFC to 0 with no flag.
- IF/ID update per cycle:
  - pc_en=0: ifid_ins and ifid_pc4 hold.
  - pc_en=1, flush_n=0: ifid_ins <= NOP_WORD, ifid_pc4 <= 0.
  - pc_en=1, flush_n=1: ifid_ins <= imem_rdata, ifid_pc4 <= pc+4.
- flag/rd update per cycle, independent of pc_en:
  - bubble_n=0: flag <= 0, rd <= 0.
  - bubble_n=1: flag <= tag, rd <= ifid_ins[20:16].
- Load-use timing: pc_en=0 and bubble_n=0 arrive together. After one cycle flag=0, which releases the stall. Net effect: exactly one stall cycle per lw dependency.
- Taken beq/j: redirect takes effect one cycle after the instruction is in ID. The wrong-path fetch is squashed to NOP by flush_n=0 in the same cycle. The following cycle sees flag=2/3, and the hazard unit bubbles.
- All outputs are registered except imem_addr, which is the pc register itself. There are no combinational paths from inputs to outputs.
- Inputs are sampled only at the posedge. X on tag while pc_en=0 must not corrupt pc.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on each posedge with pc_en=0.
  - flush_cnt increments on each posedge with pc_en=1 and flush_n=0.
  - Both wrap at 2^32 and clear on reset.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles, then release with pc_en=1, flush_n=1, bubble_n=1, tag=0, imem_rdata=32'h2008_0005. Expect imem_addr=0, then 4, then 8; ifid_ins=32'h2008_0005 and ifid_pc4=4 after the first edge.
2. Load-use stall: ifid_ins=lw $8,0($0) (32'h8C08_0000), tag=1, then one cycle of pc_en=0, bubble_n=0. Expect pc and ifid_ins held for exactly one edge, flag=0 and rd=0 after it, then normal advance.
3. Taken beq: ifid_pc4=32'h10, ifid_ins imm=16'hFFFE, tag=2, flush_n=0. Expect pc=32'h0000_0008 and ifid_ins=NOP_WORD next cycle; flag=2 captured.
4. Jump: ifid_pc4=32'h4000_0020, ifid_ins=32'h0800_0040, tag=3, flush_n=0. Expect pc=32'h4000_0100 and ifid_pc4=0.
5. Stall overrides redirect: tag=2 with pc_en=0. Expect pc unchanged. The following cycle with pc_en=1 loads bt.
6. Wrap and mid-operation reset: pc=32'hFFFF_FFFC with pc_en=1 gives pc=0. Asserting rst_n=0 during a stall restores RESET_PC and NOP_WORD on the next edge.
